core_reset_ctrl: RTL
====================

Name: core_reset_ctrl

Overview:
Parametrised reset and ROM-load sequencer for arcade cores, instantiated in the core top level between user_io/data_io and the game top. It tracks which ioctl_index ROM slots have been downloaded with real data. It generates core_reset from the OSD, button, PLL and download sources, with a programmable minimum hold after the last source clears. It also provides a bank of reset-cleared toggle latches, generalising the single pause toggle.

Parameters:
NUM_IDX, 2, number of trackable ioctl_index slots (indices 0..NUM_IDX-1); 1..8
REQ_MASK, 2'b01, NUM_IDX-bit mask; set bits are the slots that must be loaded before rom_loaded asserts
HOLD_CYCLES, 1024, extra cycles core_reset stays high after all reset sources clear; 0 allowed
NUM_TOGGLE, 1, number of toggle channels; 1..8

Ports:
clk_sys  in  1  system clock; all logic on its rising edge
reset  in  1  synchronous, active-high global clear of the whole block
osd_reset  in  1  OSD reset request (status[0])
button_reset  in  1  board button reset request
pll_locked  in  1  PLL lock; low is a reset source
ioctl_downl  in  1  download in progress
ioctl_index  in  8  download slot index
ioctl_wr  in  1  download byte strobe
toggle_btn  in  NUM_TOGGLE  raw toggle buttons, active high
core_reset  out  1  reset to game logic
rom_loaded  out  1  all REQ_MASK slots loaded
loaded_mask  out  NUM_IDX  per-slot loaded flags
toggle_state  out  NUM_TOGGLE  toggle latch outputs

Behaviour:
- Reset (reset=1): loaded_mask=0, rom_loaded=0, core_reset=1, hold counter=HOLD_CYCLES, toggle_state=0, dl_d=0, wr_seen=0, cur_idx=0. Reset has priority over all other events.
- Download tracking: dl_d is ioctl_downl registered.
  - Rising edge (ioctl_downl & ~dl_d): cur_idx<=ioctl_index, wr_seen<=ioctl_wr.
  - While ioctl_downl=1: ioctl_wr sets wr_seen.
  - Falling edge (dl_d & ~ioctl_downl): if cur_idx<NUM_IDX and wr_seen=1, set loaded_mask[cur_idx] on that edge. Otherwise loaded_mask is unchanged.
  - An ioctl_wr coincident with the rising edge counts.
  - A download of an index >= NUM_IDX is ignored but still forces reset while active.
  - A zero-byte download never sets a bit.
  - Re-downloading a loaded slot leaves its bit set.
- rom_loaded is registered: rom_loaded <= &(loaded_mask | ~REQ_MASK). It updates one cycle after the mask bit sets. If REQ_MASK=0, it is 1 on the first cycle after reset.
- raw = osd_reset | button_reset | ~pll_locked | ~rom_loaded | ioctl_downl (combinational).
- Hold counter, width clog2(HOLD_CYCLES+1), minimum 1. Per edge:
  - if raw: cnt<=HOLD_CYCLES, core_reset<=1;
  - else if cnt!=0: cnt<=cnt-1, core_reset<=1;
  - else core_reset<=0.
  - Result: raw first sampled low at edge t means core_reset goes low at edge t+HOLD_CYCLES. With HOLD_CYCLES=0, core_reset is raw delayed one cycle.
  - Any reassertion of raw during the hold reloads the counter; there is no partial credit.
- Toggles: btn_d registered per channel. On the rising edge of toggle_btn[i], toggle_state[i] flips.
  - While core_reset=1, toggle_state is forced to 0 and edges are ignored. btn_d still tracks, so a button held through reset release does not flip.
  - Channels are independent.

Test Plan:
- Power-up: reset 3 cycles, then pll_locked=1, no downloads -> core_reset stays 1 indefinitely, rom_loaded=0, loaded_mask=0.
- Download idx 0 with 16 wr strobes, HOLD_CYCLES=4, REQ_MASK=01 -> loaded_mask=01 on the falling edge, rom_loaded=1 next cycle, core_reset=0 exactly 4 edges after raw first sampled low.
- Download idx 1 with zero wr strobes, then idx 5 with data -> loaded_mask unchanged. With REQ_MASK=11 a later idx 1 load with data -> mask=11, rom_loaded=1.
- During hold countdown (cnt=2), pulse button_reset 1 cycle -> counter reloads to HOLD_CYCLES, core_reset stays 1 for a full HOLD_CYCLES again. osd_reset or pll_locked=0 after release -> core_reset=1 on the next edge, loaded_mask kept.
- NUM_TOGGLE=2, core_reset=0: pulse toggle_btn[0] twice, [1] once -> toggle_state=10 after both. Then assert button_reset -> toggle_state=00. Hold toggle_btn[1] across reset release -> no flip.
- reset asserted mid-download (ioctl_downl=1, wr_seen=1), then ioctl_downl falls -> no mask bit set, loaded_mask=0.

Source files
------------

// File: rtl/core_reset_ctrl.sv
// Reset and ROM-load sequencer for arcade cores: tracks loaded ioctl slots,
// stretches core_reset after all sources clear, and hosts reset-cleared toggles.
module core_reset_ctrl #(
    parameter int                 NUM_IDX     = 2,
    parameter logic [NUM_IDX-1:0] REQ_MASK    = 2'b01,
    parameter int                 HOLD_CYCLES = 1024,
    parameter int                 NUM_TOGGLE  = 1
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  osd_reset,
    input  logic                  button_reset,
    input  logic                  pll_locked,
    input  logic                  ioctl_downl,
    input  logic [7:0]            ioctl_index,
    input  logic                  ioctl_wr,
    input  logic [NUM_TOGGLE-1:0] toggle_btn,
    output logic                  core_reset,
    output logic                  rom_loaded,
    output logic [NUM_IDX-1:0]    loaded_mask,
    output logic [NUM_TOGGLE-1:0] toggle_state
);

    localparam int CW = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_V = CW'(HOLD_CYCLES);

    logic                  dl_d;
    logic                  wr_seen;
    logic [7:0]            cur_idx;
    logic [NUM_IDX-1:0]    idx_hit;
    logic                  dl_rise;
    logic                  dl_fall;
    logic                  raw;
    logic [CW-1:0]         cnt;
    logic [NUM_TOGGLE-1:0] btn_d;

    assign dl_rise = ioctl_downl & ~dl_d;
    assign dl_fall = dl_d & ~ioctl_downl;

    // One-hot slot select; indices at or beyond NUM_IDX decode to nothing.
    always_comb begin
        idx_hit = '0;
        for (int i = 0; i < NUM_IDX; i++) begin
            if (cur_idx == 8'(i)) begin
                idx_hit[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dl_d        <= 1'b0;
            wr_seen     <= 1'b0;
            cur_idx     <= '0;
            loaded_mask <= '0;
        end else begin
            dl_d <= ioctl_downl;
            if (dl_rise) begin
                cur_idx <= ioctl_index;
                wr_seen <= ioctl_wr;
            end else if (ioctl_downl && ioctl_wr) begin
                wr_seen <= 1'b1;
            end
            // Only a download that actually wrote data marks its slot.
            if (dl_fall && wr_seen) begin
                loaded_mask <= loaded_mask | idx_hit;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rom_loaded <= 1'b0;
        end else begin
            rom_loaded <= &(loaded_mask | ~REQ_MASK);
        end
    end

    assign raw = osd_reset | button_reset | ~pll_locked
               | ~rom_loaded | ioctl_downl;

    // Any source reloads the full hold; countdown only runs while all are quiet.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cnt        <= HOLD_V;
            core_reset <= 1'b1;
        end else if (raw) begin
            cnt        <= HOLD_V;
            core_reset <= 1'b1;
        end else if (cnt != '0) begin
            cnt        <= cnt - CW'(1);
            core_reset <= 1'b1;
        end else begin
            core_reset <= 1'b0;
        end
    end

    // btn_d keeps tracking under core_reset so a held button cannot flip on release.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            btn_d        <= '0;
            toggle_state <= '0;
        end else begin
            btn_d <= toggle_btn;
            if (core_reset) begin
                toggle_state <= '0;
            end else begin
                toggle_state <= toggle_state ^ (toggle_btn & ~btn_d);
            end
        end
    end

endmodule
